// File: rtl/result_drain.sv
// rtl/result_drain.sv - ping-pong result buffer that streams MxM matrices out one tagged element per beat
module result_drain #(
    parameter int M         = 3,
    parameter int COL_MAJOR = 0,
    localparam int IW       = $clog2(M)
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 mat_vld,
    input  logic [16*M*M-1:0]    mat,
    output logic                 mat_rdy,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [15:0]          out_data,
    output logic [IW-1:0]        out_row,
    output logic [IW-1:0]        out_col,
    output logic                 out_last
);

    localparam int NE = M * M;
    localparam int EW = $clog2(NE);
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    logic [15:0]   mem_q [2][NE];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;

    logic          accept;
    logic          beat;
    logic          last_beat;
    logic [EW-1:0] rd_idx;

    // Handshake outputs depend only on registered state, never on mat_vld/out_rdy.
    assign mat_rdy   = !rst && (cnt_q != 2'd2);
    assign out_vld   = !rst && (cnt_q != 2'd0);
    assign out_last  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign rd_idx    = EW'(row_q) * EW'(M) + EW'(col_q);
    assign out_data  = mem_q[rd_ptr_q][rd_idx];

    assign accept    = mat_vld && mat_rdy;
    assign beat      = out_vld && out_rdy;
    assign last_beat = beat && out_last;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        col_d    = col_q;

        if (accept) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        if (last_beat) begin
            row_d    = '0;
            col_d    = '0;
            rd_ptr_d = ~rd_ptr_q;
        end else if (beat) begin
            if (COL_MAJOR == 0) begin
                if (col_q == LAST_IDX) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                if (row_q == LAST_IDX) begin
                    row_d = '0;
                    col_d = col_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
        end

        // Accept and final pop in the same cycle leave the occupancy unchanged.
        case ({accept, last_beat})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

    // Buffer contents are not reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int k = 0; k < NE; k++) begin
                mem_q[wr_ptr_q][k] <= mat[16*k +: 16];
            end
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - directed self-checking bench for result_drain in both emit orders
module tb_result_drain;

    localparam int M  = 3;
    localparam int NE = M * M;
    localparam int MW = 16 * NE;

    logic          CLK = 1'b0;
    logic          rst;

    logic          mat_vld, out_rdy, mat_rdy, out_vld, out_last;
    logic [MW-1:0] mat;
    logic [15:0]   out_data;
    logic [1:0]    out_row, out_col;

    logic          mat_vld2, out_rdy2, mat_rdy2, out_vld2, out_last2;
    logic [MW-1:0] mat2;
    logic [15:0]   out_data2;
    logic [1:0]    out_row2, out_col2;

    int vecs = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    result_drain #(.M(M), .COL_MAJOR(0)) dut_row (
        .CLK(CLK), .rst(rst), .mat_vld(mat_vld), .mat(mat), .mat_rdy(mat_rdy),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    result_drain #(.M(M), .COL_MAJOR(1)) dut_col (
        .CLK(CLK), .rst(rst), .mat_vld(mat_vld2), .mat(mat2), .mat_rdy(mat_rdy2),
        .out_vld(out_vld2), .out_rdy(out_rdy2), .out_data(out_data2),
        .out_row(out_row2), .out_col(out_col2), .out_last(out_last2)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [MW-1:0] make_mat(input int base);
        logic [MW-1:0] r;
        for (int k = 0; k < NE; k++) r[16*k +: 16] = 16'(base + 10 * (k / M) + (k % M));
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        mat_vld = 1'b0; out_rdy = 1'b0; mat = '0;
        mat_vld2 = 1'b0; out_rdy2 = 1'b0; mat2 = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if ({out_vld, mat_rdy, out_vld2, mat_rdy2} !== 4'b0000) begin
                errs++;
                $display("FAIL reset_hold cyc%0d: got vld/rdy/vld2/rdy2=%b required 0000", i, {out_vld, mat_rdy, out_vld2, mat_rdy2});
            end
        end
        rst = 1'b0;
        tick();
        vecs++;
        if ({out_vld, mat_rdy, out_vld2, mat_rdy2} !== 4'b0101) begin
            errs++;
            $display("FAIL reset_release: got vld/rdy/vld2/rdy2=%b required 0101", {out_vld, mat_rdy, out_vld2, mat_rdy2});
        end
    endtask

    task automatic test_row_major;
        logic [MW-1:0] m;
        logic [21:0]   exp_v;
        m = make_mat(0);
        mat = m; mat_vld = 1'b1; out_rdy = 1'b1;
        tick();
        mat_vld = 1'b0;
        for (int e = 0; e < NE; e++) begin
            exp_v = {1'b1, m[16*e +: 16], 2'(e / M), 2'(e % M), (e == NE - 1)};
            vecs++;
            if ({out_vld, out_data, out_row, out_col, out_last} !== exp_v) begin
                errs++;
                $display("FAIL row_major beat%0d: got %h required %h", e, {out_vld, out_data, out_row, out_col, out_last}, exp_v);
            end
            tick();
        end
        vecs++;
        if (out_vld !== 1'b0) begin
            errs++;
            $display("FAIL row_major_empty: got out_vld=%b required 0", out_vld);
        end
    endtask

    task automatic test_backpressure;
        logic [MW-1:0] m;
        logic [21:0]   cur, snap, exp_v;
        logic [5:0]    pat;
        logic          stalled;
        int            e, c;
        m = make_mat(0);
        pat = 6'b101001;
        stalled = 1'b0; snap = '0; e = 0; c = 0;
        mat = m; mat_vld = 1'b1; out_rdy = 1'b0;
        tick();
        mat_vld = 1'b0;
        while (e < NE && c < 100) begin
            out_rdy = pat[c % 6];
            cur = {out_vld, out_data, out_row, out_col, out_last};
            if (stalled) begin
                vecs++;
                if (cur !== snap) begin
                    errs++;
                    $display("FAIL bp_stable cyc%0d: got %h required %h", c, cur, snap);
                end
            end
            exp_v = {1'b1, m[16*e +: 16], 2'(e / M), 2'(e % M), (e == NE - 1)};
            vecs++;
            if (cur !== exp_v) begin
                errs++;
                $display("FAIL bp_beat%0d cyc%0d: got %h required %h", e, c, cur, exp_v);
            end
            stalled = !out_rdy;
            snap = cur;
            if (out_rdy) e++;
            tick();
            c++;
        end
        vecs++;
        if (e != NE || out_vld !== 1'b0) begin
            errs++;
            $display("FAIL bp_drain: got beats=%0d out_vld=%b required beats=%0d out_vld=0", e, out_vld, NE);
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [MW-1:0] mats [3];
        logic [21:0]   exp_v;
        logic          took;
        int            e, c, sel, b;
        mats[0] = make_mat(100);
        mats[1] = make_mat(200);
        mats[2] = make_mat(300);
        out_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mat = mats[i]; mat_vld = 1'b1;
            vecs++;
            if (mat_rdy !== 1'b1) begin
                errs++;
                $display("FAIL b2b_accept%0d: got mat_rdy=%b required 1", i, mat_rdy);
            end
            tick();
        end
        mat = mats[2];
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if ({mat_rdy, out_vld, out_data} !== {1'b0, 1'b1, mats[0][15:0]}) begin
                errs++;
                $display("FAIL b2b_full%0d: got rdy/vld/data=%h required %h", i, {mat_rdy, out_vld, out_data}, {1'b0, 1'b1, mats[0][15:0]});
            end
            tick();
        end
        out_rdy = 1'b1;
        e = 0; c = 0;
        while (e < 3 * NE && c < 100) begin
            sel = e / NE; b = e % NE;
            exp_v = {1'b1, mats[sel][16*b +: 16], 2'(b / M), 2'(b % M), (b == NE - 1)};
            vecs++;
            if ({out_vld, out_data, out_row, out_col, out_last} !== exp_v) begin
                errs++;
                $display("FAIL b2b_beat%0d: got %h required %h", e, {out_vld, out_data, out_row, out_col, out_last}, exp_v);
            end
            if (e == NE - 1 || e == NE) begin
                vecs++;
                if (mat_rdy !== (e == NE)) begin
                    errs++;
                    $display("FAIL b2b_rdy_at_beat%0d: got mat_rdy=%b required %b", e, mat_rdy, (e == NE));
                end
            end
            took = mat_vld && mat_rdy;
            if (out_vld) e++;
            tick();
            c++;
            if (took) mat_vld = 1'b0;
        end
        vecs++;
        if (e != 3 * NE || out_vld !== 1'b0 || mat_rdy !== 1'b1) begin
            errs++;
            $display("FAIL b2b_drain: got beats=%0d vld=%b rdy=%b required beats=%0d vld=0 rdy=1", e, out_vld, mat_rdy, 3 * NE);
        end
        mat_vld = 1'b0;
        out_rdy = 1'b0;
    endtask

    task automatic test_col_major;
        logic [MW-1:0] mats [2];
        logic [21:0]   exp_v;
        int            sel, b, r, cl;
        mats[0] = make_mat(0);
        mats[1] = make_mat(0);
        mats[1][16*1 +: 16] = 16'hFFFF;
        mats[1][16*8 +: 16] = 16'h8000;
        out_rdy2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mat2 = mats[i]; mat_vld2 = 1'b1;
            tick();
        end
        mat_vld2 = 1'b0;
        out_rdy2 = 1'b1;
        for (int e = 0; e < 2 * NE; e++) begin
            sel = e / NE; b = e % NE;
            r = b % M; cl = b / M;
            exp_v = {1'b1, mats[sel][16*(r*M + cl) +: 16], 2'(r), 2'(cl), (b == NE - 1)};
            vecs++;
            if ({out_vld2, out_data2, out_row2, out_col2, out_last2} !== exp_v) begin
                errs++;
                $display("FAIL col_major beat%0d: got %h required %h", e, {out_vld2, out_data2, out_row2, out_col2, out_last2}, exp_v);
            end
            tick();
        end
        vecs++;
        if (out_vld2 !== 1'b0) begin
            errs++;
            $display("FAIL col_major_empty: got out_vld=%b required 0", out_vld2);
        end
        out_rdy2 = 1'b0;
    endtask

    task automatic test_reset_midstream;
        logic [MW-1:0] a, bm, d;
        logic [21:0]   exp_v;
        a = make_mat(400); bm = make_mat(500); d = make_mat(600);
        out_rdy = 1'b0;
        mat = a; mat_vld = 1'b1; tick();
        mat = bm; tick();
        mat_vld = 1'b0;
        out_rdy = 1'b1;
        repeat (4) tick();
        vecs++;
        if ({out_vld, out_data, out_row, out_col} !== {1'b1, a[16*4 +: 16], 2'd1, 2'd1}) begin
            errs++;
            $display("FAIL mid_pre_reset: got %h required %h", {out_vld, out_data, out_row, out_col}, {1'b1, a[16*4 +: 16], 2'd1, 2'd1});
        end
        rst = 1'b1;
        tick();
        vecs++;
        if ({out_vld, mat_rdy} !== 2'b00) begin
            errs++;
            $display("FAIL mid_in_reset: got vld/rdy=%b required 00", {out_vld, mat_rdy});
        end
        rst = 1'b0;
        tick();
        vecs++;
        if ({out_vld, mat_rdy} !== 2'b01) begin
            errs++;
            $display("FAIL mid_after_reset: got vld/rdy=%b required 01", {out_vld, mat_rdy});
        end
        mat = d; mat_vld = 1'b1;
        tick();
        mat_vld = 1'b0;
        for (int e = 0; e < NE; e++) begin
            exp_v = {1'b1, d[16*e +: 16], 2'(e / M), 2'(e % M), (e == NE - 1)};
            vecs++;
            if ({out_vld, out_data, out_row, out_col, out_last} !== exp_v) begin
                errs++;
                $display("FAIL mid_new_beat%0d: got %h required %h", e, {out_vld, out_data, out_row, out_col, out_last}, exp_v);
            end
            tick();
        end
        vecs++;
        if (out_vld !== 1'b0) begin
            errs++;
            $display("FAIL mid_new_empty: got out_vld=%b required 0", out_vld);
        end
        out_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_row_major();
        test_backpressure();
        test_back_to_back();
        test_col_major();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
